// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences one data-memory access per MEM-stage load/store,
// drives the dmem valid/ready request channel, formats load data and reports
// bus faults as traps. Optional request/response timeout: DMEM_TIMEOUT_EN.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ_VALID,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  input  logic [3:0]  REQ_WSTRB,
  input  logic [3:0]  REQ_RMASK,
  input  logic        REQ_IS_SIGNED,
  input  logic        FLUSH,
  output logic        STALL,
  output logic        RESP_VALID,
  output logic [31:0] RESP_RDATA,
  output logic        RESP_TRAP_VALID,
  output logic [30:0] RESP_TRAP_MCAUSE,
  output logic        DMEM_REQ_VALID,
  input  logic        DMEM_REQ_READY,
  output logic [31:0] DMEM_ADDR,
  output logic        DMEM_WE,
  output logic [3:0]  DMEM_WSTRB,
  output logic [31:0] DMEM_WDATA,
  input  logic        DMEM_RSP_VALID,
  input  logic [31:0] DMEM_RSP_RDATA,
  input  logic        DMEM_RSP_ERR
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT_RSP, S_DRAIN, S_DONE} state_e;

  state_e      state_q;
  logic [29:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [3:0]  rmask_q;
  logic        signed_q;
  logic [31:0] rdata_q;
  logic        trap_q;
  logic [30:0] mcause_q;

  logic [1:0]  sh;
  logic [3:0]  mask_sh;
  logic [31:0] w;
  logic [31:0] fmt;
  logic [31:0] rdata_d;
  logic [30:0] mcause_d;
  logic        timeout_hit;
  logic        unused_bits;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  // Timeout counter: cleared on entry to REQ, counts while an access is outstanding
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (state_q == S_IDLE) begin
      cnt_q <= '0;
    end else if (state_q == S_REQ || state_q == S_WAIT_RSP || state_q == S_DRAIN) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign unused_bits = ^REQ_ADDR[1:0];
`else
  assign timeout_hit = 1'b0;
  assign unused_bits = ^{REQ_ADDR[1:0], TIMEOUT_CYCLES[0]};
`endif

  // Load formatting: align the addressed lane to bit 0 and extend by access size
  always_comb begin
    sh = 2'd0;
    if (rmask_q[0])      sh = 2'd0;
    else if (rmask_q[1]) sh = 2'd1;
    else if (rmask_q[2]) sh = 2'd2;
    else if (rmask_q[3]) sh = 2'd3;
    mask_sh = rmask_q >> sh;
    w       = DMEM_RSP_RDATA >> {sh, 3'b000};
    case (mask_sh)
      4'hF:    fmt = w;
      4'h3:    fmt = {{16{signed_q & w[15]}}, w[15:0]};
      4'h1:    fmt = {{24{signed_q & w[7]}}, w[7:0]};
      default: fmt = '0;
    endcase
    rdata_d  = (we_q || DMEM_RSP_ERR) ? '0 : fmt;
    mcause_d = we_q ? 31'd7 : 31'd5;
  end

  // Access sequencer with registered request fields and response results
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rmask_q  <= '0;
      signed_q <= 1'b0;
      rdata_q  <= '0;
      trap_q   <= 1'b0;
      mcause_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (REQ_VALID && !FLUSH) begin
            addr_q   <= REQ_ADDR[31:2];
            we_q     <= REQ_WE;
            wdata_q  <= REQ_WDATA;
            wstrb_q  <= REQ_WE ? REQ_WSTRB : 4'h0;
            rmask_q  <= REQ_RMASK;
            signed_q <= REQ_IS_SIGNED;
            state_q  <= S_REQ;
          end
        end
        S_REQ: begin
          // An accepted handshake must be drained even if flushed the same cycle
          if (DMEM_REQ_READY) begin
            state_q <= FLUSH ? S_DRAIN : S_WAIT_RSP;
          end else if (FLUSH) begin
            state_q <= S_IDLE;
          end else if (timeout_hit) begin
            trap_q   <= 1'b1;
            mcause_q <= mcause_d;
            rdata_q  <= '0;
            state_q  <= S_DONE;
          end
        end
        S_WAIT_RSP: begin
          if (DMEM_RSP_VALID) begin
            if (FLUSH) begin
              state_q <= S_IDLE;
            end else begin
              rdata_q  <= rdata_d;
              trap_q   <= DMEM_RSP_ERR;
              mcause_q <= DMEM_RSP_ERR ? mcause_d : '0;
              state_q  <= S_DONE;
            end
          end else if (FLUSH) begin
            state_q <= S_DRAIN;
          end else if (timeout_hit) begin
            trap_q   <= 1'b1;
            mcause_q <= mcause_d;
            rdata_q  <= '0;
            state_q  <= S_DONE;
          end
        end
        S_DRAIN: begin
          if (DMEM_RSP_VALID || timeout_hit) state_q <= S_IDLE;
        end
        S_DONE: begin
          rdata_q  <= '0;
          trap_q   <= 1'b0;
          mcause_q <= '0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Output decode from state and held request/result registers
  always_comb begin
    case (state_q)
      S_IDLE:                      STALL = REQ_VALID && !FLUSH;
      S_REQ, S_WAIT_RSP, S_DRAIN:  STALL = 1'b1;
      default:                     STALL = 1'b0;
    endcase
  end

  assign DMEM_REQ_VALID   = (state_q == S_REQ);
  assign RESP_VALID       = (state_q == S_DONE);
  assign RESP_RDATA       = rdata_q;
  assign RESP_TRAP_VALID  = trap_q;
  assign RESP_TRAP_MCAUSE = mcause_q;
  assign DMEM_ADDR        = {addr_q, 2'b00};
  assign DMEM_WE          = we_q;
  assign DMEM_WSTRB       = wstrb_q;
  assign DMEM_WDATA       = wdata_q;

endmodule
